// File: rtl/quadrature_generator.sv
// Quadrature generator: turns a signed 16-bit step request into a Gray-code
// quadrature sequence on tach[1:0], one state change every dwell+1 clocks.
//
// state  | meaning
// S_IDLE | waiting for load; remaining reads 0
// S_RUN  | stepping the phase; busy high
module quadrature_generator #(
  parameter int DWELLW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        stepsh,
  input  logic [7:0]        stepsl,
  input  logic [DWELLW-1:0] dwell,
  input  logic              load,
  input  logic              abort,
  input  logic              freeze,
  input  logic              invphase,
  output logic [1:0]        tach,
  output logic              busy,
  output logic              done,
  output logic [7:0]        remh,
  output logic [7:0]        reml
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        phase_q, phase_d;
  logic              dir_q, dir_d;      // 1 = down
  logic [15:0]       rem_q, rem_d;
  logic [DWELLW-1:0] dwell_q, dwell_d;
  logic [DWELLW-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;

  logic [15:0] steps_w;
  logic [16:0] mag_w;
  logic [1:0]  phase_next_w;

  assign steps_w = {stepsh, stepsl};
  // 17-bit negate so -32768 yields +32768 without overflow.
  assign mag_w = steps_w[15] ? (17'd0 - {steps_w[15], steps_w}) : {1'b0, steps_w};

  // Up: 00->01->11->10; down is the reverse. Only one bit changes per step.
  assign phase_next_w = dir_q ? {~phase_q[0], phase_q[1]} : {phase_q[0], ~phase_q[1]};

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      phase_q <= 2'b00;
      dir_q   <= 1'b0;
      rem_q   <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: load acceptance in idle, dwell timing and stepping in run.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          dir_d   = steps_w[15];
          rem_d   = mag_w[15:0];
          dwell_d = dwell;
          cnt_d   = '0;
          if (mag_w == 17'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          rem_d   = '0;
          cnt_d   = '0;
        end else if (!freeze) begin
          if (cnt_q == dwell_q) begin
            cnt_d   = '0;
            phase_d = phase_next_w;
            rem_d   = rem_q - 16'd1;
            if (rem_q == 16'd1) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tach = invphase ? {phase_q[0], phase_q[1]} : phase_q;
  assign busy = (state_q == S_RUN);
  assign done = done_q;
  assign remh = rem_q[15:8];
  assign reml = rem_q[7:0];

endmodule
